// File: rtl/vga_fill_ctrl_pkg.sv
// vga_fill_ctrl_pkg: register map, CTRL bit positions and FSM encoding for vga_fill_ctrl
package vga_fill_ctrl_pkg;
    localparam logic [2:0] REG_ORG      = 3'd0;
    localparam logic [2:0] REG_SIZE     = 3'd1;
    localparam logic [2:0] REG_COLOR    = 3'd2;
    localparam logic [2:0] REG_CTRL     = 3'd3;
    localparam logic [2:0] REG_PIX_ADDR = 3'd4;
    localparam logic [2:0] REG_PIX_DATA = 3'd5;
    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_CLR    = 2;
    localparam int CTRL_IRQ_EN = 3;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/vga_fill_ctrl_if.sv
// vga_fill_ctrl_if: CPU register bus of the fill controller
interface vga_fill_ctrl_if;
    logic        valid;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        wstrb;
    logic [31:0] rdata;
    modport master (output valid, addr, wdata, wstrb, input rdata);
    modport slave  (input valid, addr, wdata, wstrb, output rdata);
endinterface

// File: rtl/vga_fill_ctrl_fill_xy_counter.sv
// fill_xy_counter: raster x/y counters of a rectangle fill with row wrap and last-pixel flag
module fill_xy_counter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_load,
    input  logic       i_adv,
    input  logic [7:0] i_wm1,
    input  logic [7:0] i_hm1,
    output logic [7:0] o_xc,
    output logic [7:0] o_yc,
    output logic       o_last
);
    logic [7:0] r_xc, r_yc;
    logic       w_eol;
    assign w_eol  = r_xc == i_wm1;
    assign o_last = w_eol && r_yc == i_hm1;
    assign o_xc   = r_xc;
    assign o_yc   = r_yc;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_xc <= '0;
            r_yc <= '0;
        end else if (i_load) begin
            r_xc <= '0;
            r_yc <= '0;
        end else if (i_adv) begin
            r_xc <= w_eol ? 8'd0 : r_xc + 8'd1;
            r_yc <= w_eol ? r_yc + 8'd1 : r_yc;
        end
    end
endmodule

// File: rtl/vga_fill_ctrl.sv
// vga_fill_ctrl: rectangle fill engine with CPU pixel-write priority.
// Optional macro VGA_FILL_IRQ_EN adds the irq_en bit and a registered fill-complete irq.
import vga_fill_ctrl_pkg::*;
module vga_fill_ctrl (
    input  logic               clk,
    input  logic               resetn,
    vga_fill_ctrl_if.slave     bus,
    output logic               fb_we,
    output logic [15:0]        fb_addr,
    output logic [7:0]         fb_wdata,
    output logic               irq
);
    state_t      r_state;
    logic [15:0] r_org, r_size, r_pix_addr, r_fill_org, r_fill_size;
    logic [7:0]  r_color, r_fill_color, r_pix_data;
    logic        r_pix_pend, r_done;
    logic [31:0] r_rdata;
    logic [7:0]  w_xc, w_yc;
    logic        w_wr, w_rd, w_ctrl_wr, w_start, w_abort, w_clr, w_run, w_go, w_adv, w_last, w_fill_done;
    logic        w_irq_en, w_unused;
    assign w_wr        = bus.valid & bus.wstrb;
    assign w_rd        = bus.valid & ~bus.wstrb;
    assign w_ctrl_wr   = w_wr && bus.addr == REG_CTRL;
    assign w_abort     = w_ctrl_wr & bus.wdata[CTRL_ABORT];
    assign w_start     = w_ctrl_wr & bus.wdata[CTRL_START] & ~w_abort;
    assign w_clr       = w_ctrl_wr & bus.wdata[CTRL_CLR];
    assign w_run       = r_state == RUN;
    assign w_go        = ~w_run & w_start;
    // a pending CPU pixel owns the framebuffer port; the fill holds its position
    assign w_adv       = w_run & ~r_pix_pend;
    assign w_fill_done = w_adv & w_last & ~w_abort;
    assign w_unused    = ^{bus.wdata[31:16], bus.wdata[CTRL_IRQ_EN]};
    assign bus.rdata   = r_rdata;
    assign fb_we       = r_pix_pend | w_run;
    assign fb_addr     = r_pix_pend ? r_pix_addr : {r_fill_org[15:8] + w_yc, r_fill_org[7:0] + w_xc};
    assign fb_wdata    = r_pix_pend ? r_pix_data : r_fill_color;

    fill_xy_counter u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .i_load (w_go),
        .i_adv  (w_adv),
        .i_wm1  (r_fill_size[7:0]),
        .i_hm1  (r_fill_size[15:8]),
        .o_xc   (w_xc),
        .o_yc   (w_yc),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_org        <= '0;
            r_size       <= '0;
            r_color      <= '0;
            r_pix_addr   <= '0;
            r_pix_data   <= '0;
            r_pix_pend   <= 1'b0;
            r_fill_org   <= '0;
            r_fill_size  <= '0;
            r_fill_color <= '0;
            r_done       <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (w_wr && bus.addr == REG_ORG) r_org <= bus.wdata[15:0];
            if (w_wr && bus.addr == REG_SIZE) r_size <= bus.wdata[15:0];
            if (w_wr && bus.addr == REG_COLOR) r_color <= bus.wdata[7:0];
            if (w_wr && bus.addr == REG_PIX_ADDR) r_pix_addr <= bus.wdata[15:0];
            if (w_wr && bus.addr == REG_PIX_DATA) r_pix_data <= bus.wdata[7:0];
            r_pix_pend <= w_wr && bus.addr == REG_PIX_DATA;
            if (w_go) begin
                r_fill_org   <= r_org;
                r_fill_size  <= r_size;
                r_fill_color <= r_color;
            end
            r_state <= (w_abort || w_fill_done) ? IDLE : w_go ? RUN : r_state;
            r_done  <= w_go ? 1'b0 : (r_done & ~w_clr) | w_fill_done;
            r_rdata <= (w_rd && bus.addr == REG_CTRL) ? {28'd0, w_irq_en, 1'b0, r_done, w_run} : 32'd0;
        end
    end

`ifdef VGA_FILL_IRQ_EN
    logic r_irq_en, r_irq;
    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= bus.wdata[CTRL_IRQ_EN];
            r_irq <= r_done & r_irq_en;
        end
    end
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif
endmodule

// File: tb/tb_vga_fill_ctrl.sv
// tb_vga_fill_ctrl: directed and random checks of vga_fill_ctrl against a pixel-queue reference model
module tb_vga_fill_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        fb_we, irq;
    logic [15:0] fb_addr;
    logic [7:0]  fb_wdata;
    int          n_tests = 0;
    int          n_fail = 0;
    vga_fill_ctrl_if bus();

    vga_fill_ctrl dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_wdata (fb_wdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: a fill is the queue of pixel addresses still to be written
    logic [15:0] q[$];
    logic [23:0] obs[$];
    logic [15:0] m_org, m_size, m_pixaddr, m_pa;
    logic [7:0]  m_color, m_fcol, m_pd;
    logic        m_pp, m_done, m_ien, m_irq, m_rdv;
    logic [31:0] m_rd;

    task automatic model_reset();
        q.delete();
        {m_org, m_size, m_pixaddr, m_pa, m_color, m_fcol, m_pd} = '0;
        {m_pp, m_done, m_ien, m_irq, m_rdv} = '0;
        m_rd = '0;
    endtask

    always @(negedge clk) begin
        if (!resetn) model_reset();
        else begin
            logic busy, comp, rd, wr, ctrl, abort, start, clr, go;
            logic [7:0] ax, ay;
            if (fb_we) obs.push_back({fb_addr, fb_wdata});
            if (m_pp) begin
                chk("pix_we", fb_we, 1);
                chk("pix_addr", fb_addr, m_pa);
                chk("pix_data", fb_wdata, m_pd);
            end else if (q.size() > 0) begin
                chk("fill_we", fb_we, 1);
                chk("fill_addr", fb_addr, q[0]);
                chk("fill_data", fb_wdata, m_fcol);
            end else chk("idle_we", fb_we, 0);
            if (m_rdv) chk("rdata", bus.rdata, m_rd);
            chk("irq", irq, m_irq);
            busy  = q.size() > 0;
            rd    = bus.valid & ~bus.wstrb;
            wr    = bus.valid & bus.wstrb;
            ctrl  = wr && bus.addr == 3'd3;
            abort = ctrl && bus.wdata[1];
            start = ctrl && bus.wdata[0] && !abort;
            clr   = ctrl && bus.wdata[2];
            go    = start && !busy;
            comp  = 1'b0;
            m_rdv = rd;
            m_rd  = (rd && bus.addr == 3'd3) ? {28'd0, m_ien, 1'b0, m_done, busy} : 32'd0;
`ifdef VGA_FILL_IRQ_EN
            m_irq = m_done & m_ien;
            if (ctrl) m_ien = bus.wdata[3];
`endif
            if (!m_pp && busy) begin
                void'(q.pop_front());
                comp = q.size() == 0 && !abort;
            end
            if (abort) q.delete();
            m_pp = wr && bus.addr == 3'd5;
            if (m_pp) begin
                m_pa = m_pixaddr;
                m_pd = bus.wdata[7:0];
            end
            if (go) begin
                for (int y = 0; y <= int'(m_size[15:8]); y++)
                    for (int x = 0; x <= int'(m_size[7:0]); x++) begin
                        ay = m_org[15:8] + 8'(y);
                        ax = m_org[7:0] + 8'(x);
                        q.push_back({ay, ax});
                    end
                m_fcol = m_color;
            end
            m_done = go ? 1'b0 : (m_done & ~clr) | comp;
            if (wr && bus.addr == 3'd0) m_org = bus.wdata[15:0];
            if (wr && bus.addr == 3'd1) m_size = bus.wdata[15:0];
            if (wr && bus.addr == 3'd2) m_color = bus.wdata[7:0];
            if (wr && bus.addr == 3'd4) m_pixaddr = bus.wdata[15:0];
        end
    end

    task automatic bus_op(input logic v, input logic w, input logic [2:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.valid = v;
        bus.wstrb = w;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_op(1'b1, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_op(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic rd_status(output logic [31:0] d);
        bus_op(1'b1, 1'b0, 3'd3, 32'd0);
        idle(1);
        @(negedge clk);
        d = bus.rdata;
    endtask

    logic [23:0] e_rect[6];
    logic [31:0] st;

    initial begin
        bus.valid = 1'b0;
        bus.wstrb = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        #2;
        chk("reset_we", fb_we, 0);
        chk("reset_addr", fb_addr, 0);
        chk("reset_data", fb_wdata, 0);
        chk("reset_rdata", bus.rdata, 0);
        chk("reset_irq", irq, 0);
        idle(2);
        resetn = 1'b1;
        idle(2);
        // 3x2 rectangle fill
        e_rect = '{24'h0A053C, 24'h0A063C, 24'h0A073C, 24'h0B053C, 24'h0B063C, 24'h0B073C};
        wr(3'd0, 32'h0A05);
        wr(3'd1, 32'h0102);
        wr(3'd2, 32'h3C);
        obs.delete();
        wr(3'd3, 32'h1);
        idle(10);
        chk("rect_count", obs.size(), 6);
        for (int i = 0; i < 6 && i < obs.size(); i++) chk("rect_pixel", obs[i], e_rect[i]);
        rd_status(st);
        chk("rect_status", st, 32'h2);
        // x wraps modulo 256
        wr(3'd0, 32'h00FF);
        wr(3'd1, 32'h0001);
        obs.delete();
        wr(3'd3, 32'h1);
        idle(5);
        chk("wrap_count", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("wrap_first", obs[0], 24'h00FF3C);
            chk("wrap_second", obs[1], 24'h00003C);
        end
        rd_status(st);
        chk("wrap_status", st, 32'h2);
        // CPU pixel write inserted into a 4x1 fill
        wr(3'd0, 32'h2000);
        wr(3'd1, 32'h0003);
        obs.delete();
        wr(3'd3, 32'h1);
        wr(3'd4, 32'h1234);
        wr(3'd5, 32'h77);
        idle(6);
        chk("prio_count", obs.size(), 5);
        if (obs.size() == 5) begin
            chk("prio_pixel", obs[2], 24'h123477);
            chk("prio_last_fill", obs[4], 24'h20033C);
        end
        // abort after three writes of a 16x16 fill
        wr(3'd1, 32'h0F0F);
        obs.delete();
        wr(3'd3, 32'h1);
        idle(2);
        wr(3'd3, 32'h2);
        idle(5);
        chk("abort_count", obs.size(), 3);
        rd_status(st);
        chk("abort_status", st, 32'h0);
        // reset in the middle of a fill
        wr(3'd3, 32'h1);
        idle(5);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("rst_mid_we", fb_we, 0);
        chk("rst_mid_addr", fb_addr, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(2);
        rd_status(st);
        chk("rst_status", st, 32'h0);
        // irq after a 1x1 fill, cleared by clear-done
        wr(3'd1, 32'h0000);
        wr(3'd3, 32'h8);
        wr(3'd3, 32'h9);
        idle(3);
`ifdef VGA_FILL_IRQ_EN
        chk("irq_set", irq, 1);
`else
        chk("irq_tied", irq, 0);
`endif
        wr(3'd3, 32'hC);
        idle(2);
        chk("irq_clear", irq, 0);
        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [31:0] d;
            r = $urandom_range(0, 15);
            d = $urandom;
            case (r)
                0, 1: wr(3'd0, d);
                2: wr(3'd1, {16'd0, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))});
                3: wr(3'd2, d);
                4: wr(3'd4, d);
                5: wr(3'd5, d);
                6, 7: begin
                    if (d[1] && $urandom_range(0, 3) != 0) d[1] = 1'b0;
                    wr(3'd3, {28'd0, d[3:0]});
                end
                8, 9: bus_op(1'b1, 1'b0, 3'($urandom_range(0, 7)), d);
                10: wr(3'($urandom_range(6, 7)), d);
                default: idle(1);
            endcase
        end
        idle(20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_fill_ctrl.md
VGA_FILL_CTRL -- requirements
Module: vga_fill_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL have ports: resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: valid  in  1  bus access to this block this cycle.
REQ-004 SHALL have ports: addr  in  3  word register index.
REQ-005 SHALL have ports: wdata  in  32  write data.
REQ-006 SHALL have ports: wstrb  in  1  1 = write, 0 = read.
REQ-007 SHALL have ports: rdata  out  32  read data, registered.
REQ-008 SHALL have ports: fb_we  out  1  framebuffer write enable.
REQ-009 SHALL have ports: fb_addr  out  16  framebuffer address, {y[7:0], x[7:0]}.
REQ-010 SHALL have ports: fb_wdata  out  8  framebuffer pixel.
REQ-011 SHALL have ports: irq  out  1  fill-complete interrupt.

Function
REQ-012 SHALL decode registers: 0 ORG {y0[15:8], x0[7:0]}; 1 SIZE {hm1[15:8], wm1[7:0]}; 2 COLOR [7:0]; 3 CTRL; 4 PIX_ADDR [15:0]; 5 PIX_DATA [7:0].
REQ-013 CTRL write SHALL decode: bit0 start, bit1 abort, bit2 clear done, bit3 irq_en (stored).
REQ-014 A read SHALL return data on rdata one cycle after the valid cycle: addr 3 -> {28'd0, irq_en, 1'b0, done, busy}; all other addresses -> 0.
REQ-015 The FSM SHALL have exactly two states, IDLE and RUN; busy = (state == RUN).
REQ-016 Start in IDLE SHALL load xc = 0 and yc = 0, clear done, and enter RUN.
REQ-017 Start while in RUN SHALL be ignored.
REQ-018 Each RUN cycle without CPU priority SHALL drive fb_we = 1, fb_addr = {y0+yc, x0+xc} (each byte mod 256), fb_wdata = COLOR, then advance xc.
REQ-019 When xc == wm1, the counters SHALL set xc = 0 and increment yc.
REQ-020 The write at xc == wm1 and yc == hm1 SHALL be the last; the FSM SHALL then go to IDLE and set done (sticky).
REQ-021 A fill SHALL issue exactly (wm1+1)*(hm1+1) writes, with the first write in the cycle after the start write.
REQ-022 ORG, SIZE and COLOR writes during RUN SHALL be stored but SHALL NOT affect the fill in progress; these values are latched at start.
REQ-023 A PIX_DATA write SHALL produce one fb write in the next cycle at the current PIX_ADDR with data wdata[7:0].
REQ-024 A CPU pixel write SHALL have priority over the fill; the fill SHALL stall that cycle with no counter advance.
REQ-025 Abort SHALL return the FSM to IDLE on the next edge without setting done; no fill writes SHALL occur after that edge.
REQ-026 Start and abort in the same CTRL write SHALL act as abort.
REQ-027 Clear done and a completing fill in the same cycle: done SHALL end set.
REQ-028 Outside RUN and CPU pixel writes, fb_we SHALL be 0.

Reset
REQ-029 When resetn is low, the block SHALL asynchronously force: state IDLE, done 0, irq_en 0, all registers 0, rdata 0, fb_we 0, fb_addr 0, fb_wdata 0, irq 0.
REQ-030 Reset during RUN SHALL drop fb_we immediately; no further writes SHALL occur.

Configuration
REQ-031 With macro VGA_FILL_IRQ_EN defined, irq SHALL be registered (done & irq_en).
REQ-032 Without VGA_FILL_IRQ_EN, irq SHALL be tied 0, irq_en SHALL be unimplemented, and its rdata bit SHALL read 0.

Structure
REQ-033 A shared package SHALL hold the register index constants, CTRL bit positions and the IDLE/RUN state encoding.
REQ-034 Sub-module fill_xy_counter SHALL hold the xc/yc counters, the wrap logic and the last-pixel flag.

Verification
REQ-035 ORG=0x0A05, SIZE=0x0102, COLOR=0x3C, start -> 6 writes to 0x0A05, 0x0A06, 0x0A07, 0x0B05, 0x0B06, 0x0B07, all 0x3C; then busy=0, done=1.
REQ-036 ORG=0x00FF, SIZE=0x0001, start -> writes to 0x00FF then 0x0000 (x wrap); done=1.
REQ-037 During a 4x1 fill, PIX_ADDR=0x1234 and PIX_DATA=0x77 -> write 0x1234/0x77 inserted; fill completes with exactly 4 fill writes over 5 cycles.
REQ-038 After 3 writes of a 16x16 fill, abort -> no further fb_we; done=0; status read returns 0.
REQ-039 Reset asserted mid-fill -> fb_we=0 immediately; status reads 0 after release.
REQ-040 With VGA_FILL_IRQ_EN, irq_en=1, 1x1 fill -> irq=1 one cycle after done sets; clear done -> irq=0.
